// File: rtl/parity_pkg.sv
// Shared constants for the parity datapath blocks.
// State encoding, default frame width and parity senses.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DEF_DATA_BITS = 8;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

endpackage

// File: rtl/parity_frame_controller_if.sv
// Serial-in / word-out handshake bundle for
// the parity frame controller.
interface parity_frame_controller_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 start;
  logic                 in_valid;
  logic                 in_bit;
  logic                 out_ready;
  logic                 out_valid;
  logic [DATA_BITS-1:0] out_data;
  logic                 parity_err;

  modport master (
    output start,
    output in_valid,
    output in_bit,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  parity_err
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output out_valid,
    output out_data,
    output parity_err
  );

endinterface

// File: rtl/parity_accum.sv
// Running XOR of the serial bits of a frame,
// with synchronous clear and enable.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic par_o
);

  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (clr_i) begin
      par_q <= 1'b0;
    end else if (en_i) begin
      par_q <= par_q ^ bit_i;
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/parity_frame_controller.sv
// Framed serial receiver: start, DATA_BITS bits
// LSB-first, one parity bit, then a held result.
module parity_frame_controller #(
  parameter int DATA_BITS = parity_pkg::DEF_DATA_BITS,
  parameter int ODD       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  parity_frame_controller_if.slave   bus,
  output logic                       overrun,
  output logic                       busy,
  output logic [1:0]                 state
);

  import parity_pkg::*;

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_BITS - 1);
  localparam logic SENSE = (ODD != 0);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_d;
  logic                 vld_q;
  logic                 perr_q;
  logic                 ovr_q;
  logic                 busy_q;
  logic                 par;
  logic                 acc_clr;
  logic                 acc_en;

  assign acc_clr = (state_q == IDLE) && bus.start;
  assign acc_en  = (state_q == DATA) && bus.in_valid;

  parity_accum u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .bit_i (bus.in_bit),
    .par_o (par)
  );

  // Bit lands at the slot named by the counter.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (cnt_q == CW'(i)) begin
        data_d[i] = bus.in_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          if (bus.in_valid) begin
            data_q <= data_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (bus.in_valid) begin
            perr_q  <= (par ^ bus.in_bit) != SENSE;
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Bits arriving here are dropped.
          if (bus.in_valid) begin
            ovr_q <= 1'b1;
          end
          if (bus.out_ready) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_data   = data_q;
  assign bus.parity_err = perr_q;
  assign overrun        = ovr_q;
  assign busy           = busy_q;
  assign state          = state_q;

endmodule
